// File: rtl/bju_pkg.sv
// Shared types for the branch/jump predictor: counter encodings, BTB entry layout,
// and the 2-bit saturating counter step.
package bju_pkg;

    localparam int unsigned BJU_XLEN    = 64;
    localparam int unsigned BJU_ENTRIES = 16;
    localparam int unsigned BJU_TAG_W   = 8;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef struct packed {
        logic                 valid;
        logic                 is_jump;
        logic [BJU_TAG_W-1:0] tag;
        logic [1:0]           ctr;
        logic [BJU_XLEN-1:0]  target;
    } btb_entry_t;

    localparam btb_entry_t BTB_RST = '{valid: 1'b0, is_jump: 1'b0, tag: '0,
                                       ctr: CTR_WNT, target: '0};

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        end
        return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/bju_btb.sv
// BTB/BHT storage: flop array with a combinational lookup port and an update port
// whose read side feeds the parent's read-modify-write.
module bju_btb
    import bju_pkg::*;
#(
    parameter int unsigned ENTRIES = BJU_ENTRIES,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] lk_idx_i,
    output btb_entry_t       lk_entry_o,
    input  logic [IDX_W-1:0] upd_idx_i,
    output btb_entry_t       upd_entry_o,
    input  logic             upd_we_i,
    input  btb_entry_t       upd_entry_i
);

    btb_entry_t mem_q [ENTRIES];

    assign lk_entry_o  = mem_q[lk_idx_i];
    assign upd_entry_o = mem_q[upd_idx_i];

    // Reset wins over a same-cycle write so a pending update is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= BTB_RST;
            end
        end else if (upd_we_i) begin
            mem_q[upd_idx_i] <= upd_entry_i;
        end
    end

endmodule

// File: rtl/bju_pred.sv
// Branch/jump unit with direct-mapped BTB + 2-bit BHT: IF-stage prediction and
// EX-stage resolve/redirect/update. Optional counters under BJU_PRED_STATS_EN.
module bju_pred
    import bju_pkg::*;
#(
    parameter int unsigned XLEN        = BJU_XLEN,
    parameter int unsigned BTB_ENTRIES = BJU_ENTRIES,
    parameter int unsigned TAG_W       = BJU_TAG_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    output logic [XLEN-1:0] if_pred_npc,
    input  logic            ex_valid,
    input  logic            ex_stall,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic            ex_jal,
    input  logic            ex_jalr,
    input  logic            ex_beq,
    input  logic            ex_bne,
    input  logic            ex_blt,
    input  logic            ex_bge,
    input  logic            ex_bltu,
    input  logic            ex_bgeu,
    input  logic            ex_ecall_mret,
    input  logic [XLEN-1:0] ex_csr_data,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_npc,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc
`ifdef BJU_PRED_STATS_EN
    ,
    output logic [31:0]     stat_ctl,
    output logic [31:0]     stat_miss
`endif
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);

    btb_entry_t lk_e, up_e, wr_entry_d;
    logic [IDX_W-1:0]     if_idx, ex_idx;
    logic [BJU_TAG_W-1:0] if_tag, ex_tag;
    logic lk_hit, up_hit, upd_en;
    logic is_br, is_ctl, br_taken, act_taken, eq, lt, ltu;
    logic [XLEN-1:0] pc_plus4, br_tgt, act_npc;

    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign if_tag = BJU_TAG_W'(if_pc[IDX_W+TAG_W+1:IDX_W+2]);
    assign ex_tag = BJU_TAG_W'(ex_pc[IDX_W+TAG_W+1:IDX_W+2]);

    bju_btb #(.ENTRIES(BTB_ENTRIES), .IDX_W(IDX_W)) u_btb (
        .clk         (clk),
        .rst         (rst),
        .lk_idx_i    (if_idx),
        .lk_entry_o  (lk_e),
        .upd_idx_i   (ex_idx),
        .upd_entry_o (up_e),
        .upd_we_i    (upd_en),
        .upd_entry_i (wr_entry_d)
    );

    // IF lookup sees the array before any same-cycle update lands.
    assign lk_hit        = lk_e.valid && (lk_e.tag == if_tag);
    assign if_pred_taken = lk_hit && (lk_e.is_jump || lk_e.ctr[1]);
    assign if_pred_npc   = if_pred_taken ? XLEN'(lk_e.target) : if_pc + XLEN'(4);

    assign eq  = (ex_rs1 == ex_rs2);
    assign lt  = ($signed(ex_rs1) < $signed(ex_rs2));
    assign ltu = (ex_rs1 < ex_rs2);

    assign is_br    = ex_beq | ex_bne | ex_blt | ex_bge | ex_bltu | ex_bgeu;
    assign is_ctl   = is_br | ex_jal | ex_jalr;
    assign br_taken = (ex_beq & eq) | (ex_bne & ~eq) | (ex_blt & lt) | (ex_bge & ~lt)
                    | (ex_bltu & ltu) | (ex_bgeu & ~ltu);
    assign act_taken = ex_jal | ex_jalr | br_taken;
    assign pc_plus4  = ex_pc + XLEN'(4);
    assign br_tgt    = ex_pc + ex_imm;

    always_comb begin
        act_npc = pc_plus4;
        if (ex_ecall_mret) begin
            act_npc = ex_csr_data;
        end else if (ex_jalr) begin
            act_npc = (ex_rs1 + ex_imm) & ~XLEN'(1);
        end else if (ex_jal || br_taken) begin
            act_npc = br_tgt;
        end
    end

    assign redirect    = !rst && ex_valid && !ex_stall
                       && (ex_ecall_mret || (act_npc != ex_pred_npc));
    assign redirect_pc = act_npc;

    assign upd_en = ex_valid && !ex_stall && is_ctl;
    assign up_hit = up_e.valid && (up_e.tag == ex_tag);

    // New entry; a not-taken branch keeps whatever target was stored before.
    always_comb begin
        wr_entry_d         = up_e;
        wr_entry_d.valid   = 1'b1;
        wr_entry_d.tag     = ex_tag;
        wr_entry_d.is_jump = ex_jal | ex_jalr;
        if (act_taken) begin
            wr_entry_d.target = BJU_XLEN'(act_npc);
        end
        if (up_hit) begin
            wr_entry_d.ctr = ctr_next(up_e.ctr, act_taken);
        end else begin
            wr_entry_d.ctr = act_taken ? CTR_WT : CTR_WNT;
        end
    end

    logic unused_c;
    assign unused_c = ^{ex_pred_taken, lk_e.ctr[0]};

`ifdef BJU_PRED_STATS_EN
    logic [31:0] stat_ctl_q, stat_miss_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ctl_q  <= '0;
            stat_miss_q <= '0;
        end else if (upd_en) begin
            stat_ctl_q <= stat_ctl_q + 32'd1;
            if (redirect) begin
                stat_miss_q <= stat_miss_q + 32'd1;
            end
        end
    end

    assign stat_ctl  = stat_ctl_q;
    assign stat_miss = stat_miss_q;
`endif

endmodule

// File: tb/tb_bju_pred.sv
// Scoreboard bench for bju_pred: driver pushes model expectations, monitor checks at negedge.
module tb_bju_pred;

    localparam int C_NONE = 0, C_JAL = 1, C_JALR = 2, C_BEQ = 3, C_BNE = 4, C_BLT = 5,
                   C_BGE = 6, C_BLTU = 7, C_BGEU = 8, C_ECALL = 9;

    typedef struct {
        bit          rst, valid, stall;
        int          cls;
        logic [63:0] pc, imm, rs1, rs2, csr, pred_npc, if_pc;
    } stim_t;

    typedef struct {
        bit          chk_pred;
        logic        taken;
        logic [63:0] npc;
        logic        redir;
        logic [63:0] rpc;
        int          nctl, nmiss;
        string       nm;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, if_pred_taken, ex_valid, ex_stall, redirect, ex_pred_taken;
    logic        ex_jal, ex_jalr, ex_beq, ex_bne, ex_blt, ex_bge, ex_bltu, ex_bgeu, ex_ecall_mret;
    logic [63:0] if_pc, if_pred_npc, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_csr_data, ex_pred_npc;
    logic [63:0] redirect_pc;
    logic [31:0] stat_ctl, stat_miss;

    bju_pred dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .if_pred_npc(if_pred_npc), .ex_valid(ex_valid), .ex_stall(ex_stall),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_beq(ex_beq), .ex_bne(ex_bne),
        .ex_blt(ex_blt), .ex_bge(ex_bge), .ex_bltu(ex_bltu), .ex_bgeu(ex_bgeu),
        .ex_ecall_mret(ex_ecall_mret), .ex_csr_data(ex_csr_data),
        .ex_pred_taken(ex_pred_taken), .ex_pred_npc(ex_pred_npc),
        .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef BJU_PRED_STATS_EN
        , .stat_ctl(stat_ctl), .stat_miss(stat_miss)
`endif
    );

`ifndef BJU_PRED_STATS_EN
    assign stat_ctl  = '0;
    assign stat_miss = '0;
`endif

    // Reference model: per-entry fields as plain arrays, counter as a bounded integer.
    bit          m_v   [16];
    bit          m_j   [16];
    logic [7:0]  m_tag [16];
    int          m_ctr [16];
    logic [63:0] m_tgt [16];
    bit          m_known = 0;
    int          m_nctl = 0, m_nmiss = 0;

    exp_t sb[$];
    int   total = 0, bad = 0;

    function automatic void m_pred(input logic [63:0] pc, output logic tk, output logic [63:0] npc);
        int i;
        i   = int'(pc[5:2]);
        tk  = m_v[i] && (m_tag[i] == pc[13:6]) && (m_j[i] || m_ctr[i] >= 2);
        npc = tk ? m_tgt[i] : pc + 64'd4;
    endfunction

    function automatic logic [63:0] mpn(input logic [63:0] pc);
        logic tk;
        logic [63:0] npc;
        m_pred(pc, tk, npc);
        return npc;
    endfunction

    function automatic void m_resolve(input stim_t s, output logic [63:0] npc, output bit tk);
        logic signed [63:0] a, b;
        a   = s.rs1;
        b   = s.rs2;
        tk  = 0;
        npc = s.pc + 64'd4;
        case (s.cls)
            C_JAL:   begin tk = 1; npc = s.pc + s.imm; end
            C_JALR:  begin tk = 1; npc = (s.rs1 + s.imm) & ~64'd1; end
            C_BEQ:   tk = (s.rs1 == s.rs2);
            C_BNE:   tk = (s.rs1 != s.rs2);
            C_BLT:   tk = (a < b);
            C_BGE:   tk = (a >= b);
            C_BLTU:  tk = (s.rs1 < s.rs2);
            C_BGEU:  tk = (s.rs1 >= s.rs2);
            C_ECALL: npc = s.csr;
            default: ;
        endcase
        if (tk && s.cls >= C_BEQ && s.cls <= C_BGEU) npc = s.pc + s.imm;
    endfunction

    function automatic stim_t idle(input logic [63:0] ifpc);
        stim_t s;
        s.rst = 0; s.valid = 0; s.stall = 0; s.cls = C_NONE;
        s.pc = 64'h8000_0000; s.imm = 0; s.rs1 = 0; s.rs2 = 0; s.csr = 0;
        s.pred_npc = 64'h8000_0004; s.if_pc = ifpc;
        return s;
    endfunction

    function automatic stim_t mk(input int cls, input logic [63:0] pc, imm, rs1, rs2, pnpc);
        stim_t s;
        s = idle(pc);
        s.valid = 1; s.cls = cls; s.pc = pc; s.imm = imm; s.rs1 = rs1; s.rs2 = rs2;
        s.pred_npc = pnpc;
        return s;
    endfunction

    task automatic apply(input stim_t s, input string nm);
        exp_t        e;
        logic [63:0] anpc;
        bit          tk;
        int          i;
        @(posedge clk);
        #1;
        rst = s.rst; ex_valid = s.valid; ex_stall = s.stall; if_pc = s.if_pc;
        ex_pc = s.pc; ex_imm = s.imm; ex_rs1 = s.rs1; ex_rs2 = s.rs2;
        ex_csr_data = s.csr; ex_pred_npc = s.pred_npc;
        ex_pred_taken = (s.pred_npc != s.pc + 64'd4);
        ex_jal = (s.cls == C_JAL); ex_jalr = (s.cls == C_JALR);
        ex_beq = (s.cls == C_BEQ); ex_bne = (s.cls == C_BNE);
        ex_blt = (s.cls == C_BLT); ex_bge = (s.cls == C_BGE);
        ex_bltu = (s.cls == C_BLTU); ex_bgeu = (s.cls == C_BGEU);
        ex_ecall_mret = (s.cls == C_ECALL);

        e.chk_pred = m_known;
        m_pred(s.if_pc, e.taken, e.npc);
        m_resolve(s, anpc, tk);
        e.redir = !s.rst && s.valid && !s.stall && (s.cls == C_ECALL || anpc != s.pred_npc);
        e.rpc   = anpc;
        e.nctl  = m_nctl;
        e.nmiss = m_nmiss;
        e.nm    = nm;
        sb.push_back(e);

        if (s.rst) begin
            for (int k = 0; k < 16; k++) begin m_v[k] = 0; m_ctr[k] = 1; end
            m_nctl = 0; m_nmiss = 0; m_known = 1;
        end else if (s.valid && !s.stall && s.cls >= C_JAL && s.cls <= C_BGEU) begin
            i = int'(s.pc[5:2]);
            if (m_v[i] && m_tag[i] == s.pc[13:6]) begin
                m_ctr[i] = tk ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                              : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
            end else begin
                m_ctr[i] = tk ? 2 : 1;
            end
            if (tk) m_tgt[i] = anpc;
            m_v[i] = 1; m_tag[i] = s.pc[13:6]; m_j[i] = (s.cls == C_JAL || s.cls == C_JALR);
            m_nctl++;
            if (e.redir) m_nmiss++;
        end
    endtask

    task automatic chk(input string nm, input string what, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s got=%h want=%h", nm, what, act, exp);
        end
    endtask

    // Monitor: outputs are combinational, so every cycle presents one result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk(e.nm, "redirect", 64'(redirect), 64'(e.redir));
                if (e.redir) chk(e.nm, "redirect_pc", redirect_pc, e.rpc);
                if (e.chk_pred) begin
                    chk(e.nm, "pred_taken", 64'(if_pred_taken), 64'(e.taken));
                    chk(e.nm, "pred_npc", if_pred_npc, e.npc);
`ifdef BJU_PRED_STATS_EN
                    chk(e.nm, "stat_ctl", 64'(stat_ctl), 64'(32'(e.nctl)));
                    chk(e.nm, "stat_miss", 64'(stat_miss), 64'(32'(e.nmiss)));
`endif
                end
            end
        end
    end

    initial begin
        stim_t       s;
        logic [63:0] vals [4];
        logic [63:0] pc;
        vals[0] = 64'd0; vals[1] = 64'd5; vals[2] = 64'hFFFF_FFFF_FFFF_FFFB;
        vals[3] = 64'h8000_0000_0000_0000;

        s = idle(64'h8000_0000); s.rst = 1;
        apply(s, "reset0");
        apply(s, "reset1");
        apply(idle(64'h8000_0000), "t1_lookup");

        apply(mk(C_BEQ, 64'h8000_0010, 64'h20, 5, 5, 64'h8000_0014), "t2_beq");
        apply(idle(64'h8000_0010), "t2_lookup");

        for (int k = 0; k < 3; k++)
            apply(mk(C_BEQ, 64'h8000_0010, 64'h20, 5, 6, mpn(64'h8000_0010)), "t3_beq_nt");
        apply(idle(64'h8000_0010), "t3_lookup");

        for (int k = 0; k < 2; k++)
            apply(mk(C_JALR, 64'h8000_0040, 0, 64'h8000_1003, 0, mpn(64'h8000_0040)), "t4_jalr");
        apply(mk(C_JALR, 64'h8000_0040, 0, 64'h8000_2001, 0, mpn(64'h8000_0040)), "t4_jalr_new");
        apply(idle(64'h8000_0040), "t4_lookup");

        for (int k = 0; k < 2; k++) begin
            s = mk(C_BNE, 64'h8000_0080, 64'h40, 1, 2, 64'h8000_0084); s.stall = 1;
            apply(s, "t5_stall");
        end
        apply(mk(C_BNE, 64'h8000_0080, 64'h40, 1, 2, 64'h8000_0084), "t5_release");
        apply(idle(64'h8000_0080), "t5_lookup");

        apply(mk(C_JAL, 64'h8000_0100, 64'h40, 0, 0, 64'h8000_0104), "t6_same_idx");
        apply(idle(64'h8000_0100), "t6_lookup");
        s = mk(C_JAL, 64'h8000_0200, 64'h80, 0, 0, 64'h8000_0204); s.rst = 1;
        apply(s, "t6_rst_upd");
        apply(idle(64'h8000_0200), "t6_after_rst");
        apply(idle(64'h8000_0100), "t6_after_rst2");
        apply(mk(C_ECALL, 64'h8000_0300, 0, 0, 0, 64'h8000_0304), "ecall");

        for (int n = 0; n < 600; n++) begin
            pc = 64'h8000_0000 + 64'(4 * $urandom_range(0, 47));
            s = mk(int'($urandom_range(0, 9)), pc, 64'($urandom_range(0, 255)) << 2,
                   vals[$urandom_range(0, 3)], vals[$urandom_range(0, 3)], mpn(pc));
            if ($urandom_range(0, 1) == 1) s.imm = -s.imm;
            if ($urandom_range(0, 4) == 0) s.pred_npc = 64'h8000_0000 + 64'(4 * $urandom_range(0, 63));
            s.csr   = 64'h8000_0000 + 64'($urandom_range(0, 255) << 2);
            s.valid = ($urandom_range(0, 9) != 0);
            s.stall = ($urandom_range(0, 6) == 0);
            s.rst   = ($urandom_range(0, 99) == 0);
            s.if_pc = 64'h8000_0000 + 64'(4 * $urandom_range(0, 47));
            apply(s, "rand");
        end

        apply(idle(64'h8000_0000), "drain");
        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
